// File: rtl/ntt_ctrl_if.sv
// Control/datapath bundle between the NTT sequencer and its top-level controller,
// coefficient RAM, twiddle ROM and butterfly pipeline.
interface ntt_ctrl_if #(
  parameter int LOGN = 8
);
  // start is a level sampled only while idle (no ready); busy stays high from the
  // cycle after acceptance until the done pulse; rd_en/wr_en are single-cycle
  // strobes with no back-pressure, addresses valid whenever the strobe is high.
  logic            start;
  logic            mode;
  logic            busy;
  logic            done;
  logic [2:0]      layer;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] twf_addr;
  logic            bf_sel;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;

  modport master (
    output start, mode,
    input  busy, done, layer, rd_en, rd_addr_a, rd_addr_b, twf_addr,
    input  bf_sel, wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, mode,
    output busy, done, layer, rd_en, rd_addr_a, rd_addr_b, twf_addr,
    output bf_sel, wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_ctrl.sv
// In-place NTT/INTT sequencer: issues one butterfly per cycle per layer, then drains
// the read+butterfly pipeline before the next layer reads its freshly written data.
module ntt_ctrl #(
  parameter int N      = 256,
  parameter int LOGN   = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 5
) (
  input  logic       clk,
  input  logic       rst,
  ntt_ctrl_if.slave  ctrl,
  output logic [1:0] o_state
);
  localparam int D  = RD_LAT + BF_LAT;
  localparam int DW = $clog2(D);
  localparam logic [DW-1:0]   DCNT_LAST  = DW'(D - 1);
  localparam logic [LOGN-2:0] CNT_LAST   = (LOGN-1)'(N / 2 - 1);
  localparam logic [2:0]      LAST_LAYER = 3'(LOGN - 2);
  localparam logic [LOGN-1:0] ONE        = LOGN'(1);
  localparam logic [LOGN-2:0] ONE_T      = (LOGN-1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_mode;
  logic            r_busy;
  logic            r_done;
  logic [2:0]      r_layer;
  logic [LOGN-2:0] r_cnt;
  logic [DW-1:0]   r_dcnt;
  logic            r_rd_en;
  logic [LOGN-1:0] r_rd_a;
  logic [LOGN-1:0] r_rd_b;
  logic [LOGN-2:0] r_twf;
  logic            r_wr_en;
  logic [LOGN-1:0] r_wr_a;
  logic [LOGN-1:0] r_wr_b;
  logic [D-2:0]    r_dl_v;
  logic [LOGN-1:0] r_dl_a [D-1];
  logic [LOGN-1:0] r_dl_b [D-1];

  // Returns {addr_a, addr_b, twiddle} for butterfly idx of the given layer.
  function automatic logic [3*LOGN-2:0] calc(input logic [2:0] lyr, input logic md,
                                             input logic [LOGN-2:0] idx);
    logic [LOGN-1:0] i_ext, len, g, o, a, b;
    logic [LOGN-2:0] t;
    int              sh;
    i_ext = {1'b0, idx};
    if (md) sh = int'(lyr) + 1;
    else    sh = LOGN - 1 - int'(lyr);
    len = ONE << sh;
    g   = i_ext >> sh;
    o   = i_ext & (len - ONE);
    a   = (g << (sh + 1)) + o;
    b   = a + len;
    // INTT walks the twiddle table downwards; the 2^(LOGN-1) term wraps to 0 on layer 0.
    if (md) t = (ONE_T << (LOGN - 1 - int'(lyr))) - ONE_T - g[LOGN-2:0];
    else    t = (ONE_T << lyr) + g[LOGN-2:0];
    return {a, b, t};
  endfunction

  logic [LOGN-2:0]   w_cnt_inc;
  logic [3*LOGN-2:0] w_next_issue;
  logic [3*LOGN-2:0] w_first_acc;
  logic [3*LOGN-2:0] w_first_next;

  assign w_cnt_inc    = r_cnt + (LOGN-1)'(1);
  assign w_next_issue = calc(r_layer, r_mode, w_cnt_inc);
  assign w_first_acc  = calc(3'd0, ctrl.mode, '0);
  assign w_first_next = calc(r_layer + 3'd1, r_mode, '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_layer <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_twf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (ctrl.start) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_mode  <= ctrl.mode;
            r_layer <= '0;
            r_cnt   <= '0;
            r_rd_en <= 1'b1;
            {r_rd_a, r_rd_b, r_twf} <= w_first_acc;
          end
        end
        S_ISSUE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
            r_dcnt  <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            {r_rd_a, r_rd_b, r_twf} <= w_next_issue;
          end
        end
        S_DRAIN: begin
          // Leave only when the last write of this layer is on wr_en this cycle.
          if (r_dcnt == DCNT_LAST) begin
            if (r_layer == LAST_LAYER) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_layer <= r_layer + 3'd1;
              r_cnt   <= '0;
              r_rd_en <= 1'b1;
              {r_rd_a, r_rd_b, r_twf} <= w_first_next;
            end
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_layer <= '0;
          r_mode  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address/valid delay line: a read strobe in cycle t becomes wr_en in cycle t+D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_v  <= '0;
      r_wr_en <= 1'b0;
      r_wr_a  <= '0;
      r_wr_b  <= '0;
      for (int k = 0; k < D - 1; k++) begin
        r_dl_a[k] <= '0;
        r_dl_b[k] <= '0;
      end
    end else begin
      r_dl_v[0] <= r_rd_en;
      r_dl_a[0] <= r_rd_a;
      r_dl_b[0] <= r_rd_b;
      for (int k = 1; k < D - 1; k++) begin
        r_dl_v[k] <= r_dl_v[k-1];
        r_dl_a[k] <= r_dl_a[k-1];
        r_dl_b[k] <= r_dl_b[k-1];
      end
      r_wr_en <= r_dl_v[D-2];
      r_wr_a  <= r_dl_a[D-2];
      r_wr_b  <= r_dl_b[D-2];
    end
  end

  assign ctrl.busy      = r_busy;
  assign ctrl.done      = r_done;
  assign ctrl.layer     = r_layer;
  assign ctrl.rd_en     = r_rd_en;
  assign ctrl.rd_addr_a = r_rd_a;
  assign ctrl.rd_addr_b = r_rd_b;
  assign ctrl.twf_addr  = r_twf;
  assign ctrl.bf_sel    = r_mode;
  assign ctrl.wr_en     = r_wr_en;
  assign ctrl.wr_addr_a = r_wr_a;
  assign ctrl.wr_addr_b = r_wr_b;
  assign o_state        = r_state;
endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: expected reads/writes/status per run are queued at
// start, and a negedge monitor pops and compares them as the DUT presents them.
module tb_ntt_ctrl;
  localparam int W_RD = 39;  // {cycle16, a8, b8, twf7}
  localparam int W_WR = 32;  // {cycle16, a8, b8}
  localparam int W_PT = 25;  // {cycle16, busy, done, rd_en, wr_en, state2, layer3}
  localparam int W_AD = 40;  // {cycle16, rd_en, a8, b8, twf7}

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state;

  ntt_ctrl_if #(.LOGN(8)) bus ();

  ntt_ctrl #(.N(256), .LOGN(8), .RD_LAT(1), .BF_LAT(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl    (bus),
    .o_state (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int   tests = 0;
  int   fails = 0;
  int   base  = 0;
  bit   mon_en = 1'b0;
  logic exp_mode = 1'b0;
  int   n_rd, n_wr, n_busy, n_done;

  logic [W_RD-1:0] exp_rd_q[$];
  logic [W_WR-1:0] exp_wr_q[$];
  logic [W_PT-1:0] exp_pt_q[$];
  logic [W_AD-1:0] exp_ad_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  function automatic logic [W_PT-1:0] pt(input int c, input bit bz, input bit dn, input bit rd,
                                          input bit wr, input int st, input int ly);
    return {16'(c), bz, dn, rd, wr, 2'(st), 3'(ly)};
  endfunction

  function automatic logic [W_AD-1:0] ad(input int c, input int a, input int b, input int t);
    return {16'(c), 1'b1, 8'(a), 8'(b), 7'(t)};
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({bus.busy, bus.done, bus.layer, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                bus.twf_addr, bus.bf_sel, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b, state});
  endfunction

  // Expected traffic for a full run, cycles relative to the start-accept cycle (0).
  task automatic push_run(input logic md);
    for (int l = 0; l < 7; l++) begin
      for (int i = 0; i < 128; i++) begin
        int len, g, o, a, b, t, c;
        len = md ? (2 << l) : (128 >> l);
        g   = i / len;
        o   = i % len;
        a   = 2 * len * g + o;
        b   = a + len;
        t   = md ? (256 / len - 1 - g) : (256 / (2 * len) + g);
        c   = 1 + 134 * l + i;
        exp_rd_q.push_back({16'(c), 8'(a), 8'(b), 7'(t)});
        exp_wr_q.push_back({16'(c + 6), 8'(a), 8'(b)});
      end
    end
    exp_pt_q.push_back(pt(0,   0, 0, 0, 0, 0, 0));
    exp_pt_q.push_back(pt(1,   1, 0, 1, 0, 1, 0));
    exp_pt_q.push_back(pt(7,   1, 0, 1, 1, 1, 0));
    exp_pt_q.push_back(pt(129, 1, 0, 0, 1, 2, 0));
    exp_pt_q.push_back(pt(134, 1, 0, 0, 1, 2, 0));
    exp_pt_q.push_back(pt(135, 1, 0, 1, 0, 1, 1));
    exp_pt_q.push_back(pt(938, 1, 0, 0, 1, 2, 6));
    exp_pt_q.push_back(pt(939, 1, 1, 0, 0, 3, 6));
    if (!md) begin
      exp_ad_q.push_back(ad(1,   0,   128, 1));
      exp_ad_q.push_back(ad(2,   1,   129, 1));
      exp_ad_q.push_back(ad(135, 0,   64,  2));
      exp_ad_q.push_back(ad(199, 128, 192, 3));
      exp_ad_q.push_back(ad(805, 0,   2,   64));
      exp_ad_q.push_back(ad(806, 1,   3,   64));
      exp_ad_q.push_back(ad(807, 4,   6,   65));
      exp_ad_q.push_back(ad(932, 253, 255, 127));
    end else begin
      exp_ad_q.push_back(ad(1,   0, 2,   127));
      exp_ad_q.push_back(ad(3,   4, 6,   126));
      exp_ad_q.push_back(ad(805, 0, 128, 1));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    int              rel;
    logic [W_RD-1:0] e_rd;
    logic [W_WR-1:0] e_wr;
    logic [W_PT-1:0] e_pt;
    logic [W_AD-1:0] e_ad;
    if (mon_en) begin
      rel = cyc - base;
      if (bus.busy) n_busy++;
      if (bus.done) n_done++;
      if (bus.rd_en) begin
        n_rd++;
        if (exp_rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: got rd_en=1 at rel cycle %0d expected none", rel);
        end else begin
          e_rd = exp_rd_q.pop_front();
          check("rd_issue", 64'({16'(rel), bus.rd_addr_a, bus.rd_addr_b, bus.twf_addr}), 64'(e_rd));
          check("bf_sel", 64'(bus.bf_sel), 64'(exp_mode));
        end
      end
      if (bus.wr_en) begin
        n_wr++;
        if (exp_wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: got wr_en=1 at rel cycle %0d expected none", rel);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("wr_issue", 64'({16'(rel), bus.wr_addr_a, bus.wr_addr_b}), 64'(e_wr));
        end
      end
      while (exp_pt_q.size() > 0) begin
        e_pt = exp_pt_q[0];
        if (e_pt[24:9] != 16'(rel)) break;
        void'(exp_pt_q.pop_front());
        check("status", 64'({16'(rel), bus.busy, bus.done, bus.rd_en, bus.wr_en, state, bus.layer}),
              64'(e_pt));
      end
      while (exp_ad_q.size() > 0) begin
        e_ad = exp_ad_q[0];
        if (e_ad[39:24] != 16'(rel)) break;
        void'(exp_ad_q.pop_front());
        check("directed_rd", 64'({16'(rel), bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.twf_addr}),
              64'(e_ad));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic md);
    base     = cyc;
    exp_mode = md;
    n_rd = 0; n_wr = 0; n_busy = 0; n_done = 0;
    push_run(md);
    bus.mode  = md;
    bus.start = 1'b1;
    mon_en    = 1'b1;
  endtask

  // Runs to rel cycle 940; a stray start at 300 and a mode flip at 5 must be ignored.
  task automatic body_run(input bit chain);
    for (int rel = 1; rel <= 940; rel++) begin
      @(posedge clk); #1;
      if (rel == 1)   bus.start = 1'b0;
      if (rel == 5)   bus.mode  = ~exp_mode;
      if (rel == 300) bus.start = 1'b1;
      if (rel == 301) bus.start = 1'b0;
      if (rel == 939 && chain) begin
        bus.start = 1'b1;
        bus.mode  = 1'b1;
      end
    end
    check("rd_count",   64'(n_rd),   64'(896));
    check("wr_count",   64'(n_wr),   64'(896));
    check("busy_count", 64'(n_busy), 64'(939));
    check("done_count", 64'(n_done), 64'(1));
    check("rd_q_left",  64'(exp_rd_q.size()), 64'(0));
    check("wr_q_left",  64'(exp_wr_q.size()), 64'(0));
    check("pt_q_left",  64'(exp_pt_q.size()), 64'(0));
    check("ad_q_left",  64'(exp_ad_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", 64'({state, bus.busy, bus.rd_en}), 64'(0));

    // NTT, then an INTT whose start is held from the DONE cycle into IDLE.
    start_run(1'b0);
    body_run(1'b1);
    start_run(1'b1);
    body_run(1'b0);

    // Asynchronous reset in the middle of layer 0.
    @(posedge clk); #1;
    start_run(1'b0);
    for (int rel = 1; rel <= 50; rel++) begin
      @(posedge clk); #1;
      if (rel == 1) bus.start = 1'b0;
    end
    check("rd_before_rst", 64'(bus.rd_en), 64'(1));
    mon_en = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_pt_q.delete();
    exp_ad_q.delete();
    #2 rst = 1'b1;
    #1;
    check("rst_async_zero", all_outputs(), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.wr_en || bus.busy || bus.rd_en) seen = 1'b1;
    end
    check("quiet_after_rst", 64'(seen), 64'(0));
    @(posedge clk); #1;
    start_run(1'b0);
    body_run(1'b0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
